// File: rtl/cp0_nested_intc.sv
// CP0 interrupt unit: prioritised, maskable sources with an EPC/level stack for nested service.
// Build option CP0_LEVEL_TRIG_EN makes pending follow the synchronised request level.
module cp0_nested_intc #(
   parameter int NUM_SRC   = 3,
   parameter int EPC_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        id_instr,
   input  logic [31:0]        wb_instr,
   input  logic [31:0]        wb_din,
   input  logic [31:0]        ex_pc,
   input  logic [NUM_SRC-1:0] intsrc,
   output logic               INT,
   output logic               RegToCP0,
   output logic               CP0ToReg,
   output logic [31:0]        id_dout,
   output logic [31:0]        epc_out,
   output logic               eret,
   output logic [3:0]         nest_depth
);
   localparam int          IDX_W     = (EPC_DEPTH > 1) ? $clog2(EPC_DEPTH) : 1;
   localparam logic [3:0]  DEPTH     = 4'(EPC_DEPTH);
   localparam logic [31:0] ERET_WORD = 32'h4200_0018;

   logic               mtc0;
   logic               mfc0;
   logic [4:0]         wb_addr;
   logic [4:0]         id_addr;
   logic               ie;
   logic [NUM_SRC-1:0] im;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] sync_p0;
   logic [NUM_SRC-1:0] sync_p1;
   logic [3:0]         cur_lvl;
   logic [3:0]         int_lvl;
   logic [3:0]         win_lvl;
   logic [3:0]         sp;
   logic [3:0]         sp_m1;
   logic [IDX_W-1:0]   push_idx;
   logic [IDX_W-1:0]   top_idx;
   logic [31:0]        stk_epc [EPC_DEPTH];
   logic [3:0]         stk_lvl [EPC_DEPTH];
   logic               take;
   logic               ret;
   logic               raise;
   logic               wr_ie;
   logic               wr_epc;
   logic [7:0]         im8;
   logic [7:0]         pend8;
   logic [7:0]         lvl_oh;
   logic               unused_ok;

   function automatic logic [3:0] top_level(input logic [NUM_SRC-1:0] r);
      logic [3:0] lvl;
      lvl = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (r[i]) lvl = 4'(i + 1);
      end
      return lvl;
   endfunction

   assign mtc0       = (wb_instr[31:21] == 11'b01000000100);
   assign mfc0       = (id_instr[31:21] == 11'b01000000000);
   assign eret       = (id_instr == ERET_WORD);
   assign wb_addr    = wb_instr[15:11];
   assign id_addr    = id_instr[15:11];
   assign RegToCP0   = mtc0;
   assign CP0ToReg   = mfc0;
   assign nest_depth = sp;
   assign unused_ok  = ^{wb_instr[20:16], wb_instr[10:0]};

   assign sp_m1    = sp - 4'd1;
   assign push_idx = sp[IDX_W-1:0];
   assign top_idx  = sp_m1[IDX_W-1:0];

   // INT high means the CPU takes the interrupt on this edge; ERET in ID is flushed then.
   assign take    = INT;
   assign ret     = eret & ~INT & (sp != 4'd0);
   assign req     = pending & im;
   assign win_lvl = top_level(req);
   assign raise   = ie & ~INT & ~eret & (sp < DEPTH) & (win_lvl > cur_lvl);
   assign wr_ie   = mtc0 & (wb_addr == 5'd12);
   assign wr_epc  = mtc0 & (wb_addr == 5'd14) & (sp != 4'd0);
   assign epc_out = (sp == 4'd0) ? 32'd0 : stk_epc[top_idx];

   // Stage p0/p1: two-flop synchroniser on the raw requests
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= intsrc;
         sync_p1 <= sync_p0;
      end
   end

`ifdef CP0_LEVEL_TRIG_EN
   assign pending = sync_p1;
`else
   logic [NUM_SRC-1:0] sync_p2;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] clr;

   assign rise = sync_p1 & ~sync_p2;

   always_comb begin
      clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ret && (cur_lvl == 4'(i + 1))) clr[i] = 1'b1;
      end
   end

   // Stage p2: edge detect; a new edge outranks a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p2 <= '0;
         pending <= '0;
      end else begin
         sync_p2 <= sync_p1;
         pending <= (pending & ~clr) | rise;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         INT     <= 1'b0;
         int_lvl <= '0;
         ie      <= 1'b0;
         im      <= '1;
         cur_lvl <= '0;
         sp      <= '0;
      end else begin
         INT <= raise;
         if (raise) int_lvl <= win_lvl;
         if (take) begin
            sp      <= sp + 4'd1;
            cur_lvl <= int_lvl;
         end else if (ret) begin
            sp      <= sp_m1;
            cur_lvl <= stk_lvl[top_idx];
         end
         if (wr_ie) begin
            ie <= wb_din[0];
            im <= wb_din[8 +: NUM_SRC];
         end else if (take) begin
            ie <= 1'b0;
         end else if (eret & ~INT) begin
            ie <= 1'b1;
         end
      end
   end

   // An EPC write on a take cycle hits the old top; the push fills the next slot.
   always_ff @(posedge clk) begin
      if (wr_epc) stk_epc[top_idx] <= wb_din;
      if (take) begin
         stk_epc[push_idx] <= ex_pc;
         stk_lvl[push_idx] <= cur_lvl;
      end
   end

   always_comb begin
      id_dout = '0;
      im8     = '0;
      pend8   = '0;
      lvl_oh  = '0;
      im8[NUM_SRC-1:0]   = im;
      pend8[NUM_SRC-1:0] = pending;
      if (cur_lvl != 4'd0) lvl_oh[3'(cur_lvl - 4'd1)] = 1'b1;
      case (id_addr)
         5'd12:   id_dout = {4'b0, sp, 8'b0, im8, 7'b0, ie};
         5'd13:   id_dout = {8'b0, pend8, lvl_oh, 8'b0};
         5'd14:   id_dout = epc_out;
         default: id_dout = '0;
      endcase
   end
endmodule

// File: tb/tb_cp0_nested_intc.sv
// Bench for cp0_nested_intc: directed nesting scenarios plus a random run against a
// queue-based model of the interrupt rules.
module tb_cp0_nested_intc;
   localparam int SRC   = 3;
   localparam int DEPTH = 2;
   localparam logic [31:0] ERET_W = 32'h4200_0018;

   typedef struct {
      logic [31:0] pc;
      int          lvl;
   } ent_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [31:0]    id_instr, wb_instr, wb_din, ex_pc;
   logic [SRC-1:0] intsrc;
   logic           INT, RegToCP0, CP0ToReg, eret;
   logic [31:0]    id_dout, epc_out;
   logic [3:0]     nest_depth;

   int checks = 0;
   int fails  = 0;

   bit             m_int, m_ie;
   int             m_int_lvl, m_cur;
   logic [SRC-1:0] m_im, m_pend, hist0, hist1, hist2;
   ent_t           stk[$];

   cp0_nested_intc #(.NUM_SRC(SRC), .EPC_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .wb_instr(wb_instr),
      .wb_din(wb_din), .ex_pc(ex_pc), .intsrc(intsrc), .INT(INT),
      .RegToCP0(RegToCP0), .CP0ToReg(CP0ToReg), .id_dout(id_dout),
      .epc_out(epc_out), .eret(eret), .nest_depth(nest_depth)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   function automatic logic [31:0] mfc0_w(input logic [4:0] a);
      return {11'b01000000000, 5'd0, a, 11'd0};
   endfunction

   function automatic logic [31:0] mtc0_w(input logic [4:0] a);
      return {11'b01000000100, 5'd0, a, 11'd0};
   endfunction

   function automatic logic [31:0] m_epc();
      if (stk.size() == 0) return 32'd0;
      return stk[stk.size()-1].pc;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      logic [7:0] oh;
      oh = '0;
      if (m_cur > 0) oh[m_cur-1] = 1'b1;
      case (a)
         5'd12:   return {4'b0, 4'(stk.size()), 8'b0, 5'b0, m_im, 7'b0, m_ie};
         5'd13:   return {8'b0, 5'b0, m_pend, oh, 8'b0};
         5'd14:   return m_epc();
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      m_int = 0; m_ie = 0; m_int_lvl = 0; m_cur = 0;
      m_im = '1; m_pend = '0; hist0 = '0; hist1 = '0; hist2 = '0;
      stk.delete();
   endtask

   // Advance the model by one clock using the inputs about to be sampled.
   task automatic model_step();
      logic [SRC-1:0] rise, req, np;
      int   win;
      bit   is_eret, is_mtc0, raise, ret;
      ent_t e;
      is_mtc0 = (wb_instr[31:21] == 11'b01000000100);
      is_eret = (id_instr == ERET_W);
      rise = hist1 & ~hist2;
      req  = m_pend & m_im;
      win  = 0;
      for (int i = 0; i < SRC; i++) if (req[i]) win = i + 1;
      raise = m_ie && !m_int && !is_eret && (stk.size() < DEPTH) && (win > m_cur);
      ret   = is_eret && !m_int && (stk.size() > 0);
      np = m_pend;
      for (int i = 0; i < SRC; i++) begin
         if (rise[i]) np[i] = 1'b1;
         else if (ret && m_cur == i + 1) np[i] = 1'b0;
      end
      if (is_mtc0 && wb_instr[15:11] == 5'd14 && stk.size() > 0) begin
         e = stk[stk.size()-1]; e.pc = wb_din; stk[stk.size()-1] = e;
      end
      if (m_int) begin
         e.pc = ex_pc; e.lvl = m_cur; stk.push_back(e);
         m_cur = m_int_lvl; m_ie = 0;
      end else if (ret) begin
         e = stk.pop_back(); m_cur = e.lvl; m_ie = 1;
      end else if (is_eret) begin
         m_ie = 1;
      end
      if (is_mtc0 && wb_instr[15:11] == 5'd12) begin
         m_ie = wb_din[0]; m_im = wb_din[8 +: SRC];
      end
      if (raise) m_int_lvl = win;
      m_int = raise;
      m_pend = np;
      hist2 = hist1; hist1 = hist0; hist0 = intsrc;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk); #1;
      ex_pc = $urandom & 32'hFFFF_FFFC;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      id_instr = mfc0_w(a); #1; v = id_dout;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      wb_instr = mtc0_w(a); wb_din = d; cyc(); wb_instr = '0; wb_din = '0;
   endtask

   task automatic pulse(input int s);
      intsrc = '0; intsrc[s] = 1'b1; cyc(); intsrc = '0;
   endtask

   task automatic eret_op();
      id_instr = ERET_W; cyc(); id_instr = '0;
   endtask

   task automatic wait_int(input int budget, output int lat);
      lat = -1;
      for (int k = 1; k <= budget; k++) begin
         cyc();
         if (INT === 1'b1) begin lat = k; break; end
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst_n = 1'b0; id_instr = '0; wb_instr = '0; wb_din = '0; intsrc = '0; ex_pc = '0;
      m_reset();
      repeat (2) @(posedge clk); #1;
      checks++; if (INT !== 1'b0) begin fails++; $display("FAIL rst_int: got %b want 0", INT); end
      checks++; if (nest_depth !== 4'd0) begin fails++; $display("FAIL rst_sp: got %0d want 0", nest_depth); end
      checks++; if (epc_out !== 32'd0) begin fails++; $display("FAIL rst_epc: got %h want 0", epc_out); end
      rd(12, v);
      checks++; if (v !== 32'h0000_0700) begin fails++; $display("FAIL rst_r12: got %h want 00000700", v); end
      checks++; if (CP0ToReg !== 1'b1) begin fails++; $display("FAIL dec_mfc0: got %b want 1", CP0ToReg); end
      rd(13, v);
      checks++; if (v !== 32'd0) begin fails++; $display("FAIL rst_r13: got %h want 0", v); end
      wb_instr = mtc0_w(12); id_instr = ERET_W; #1;
      checks++; if (RegToCP0 !== 1'b1) begin fails++; $display("FAIL dec_mtc0: got %b want 1", RegToCP0); end
      checks++; if (eret !== 1'b1) begin fails++; $display("FAIL dec_eret: got %b want 1", eret); end
      wb_instr = '0; id_instr = '0; #1;
      checks++; if (eret !== 1'b0 || RegToCP0 !== 1'b0) begin fails++; $display("FAIL dec_idle: got %b%b want 00", eret, RegToCP0); end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_single();
      int lat; logic [31:0] pc, v;
      mtc0(12, 32'h0000_0701);
      pulse(1);
      wait_int(8, lat);
      checks++; if (lat != 3) begin fails++; $display("FAIL single_lat: got %0d want 3", lat); end
      pc = ex_pc; cyc();
      checks++; if (INT !== 1'b0) begin fails++; $display("FAIL single_width: got %b want 0", INT); end
      checks++; if (nest_depth !== 4'd1) begin fails++; $display("FAIL single_sp: got %0d want 1", nest_depth); end
      checks++; if (epc_out !== pc) begin fails++; $display("FAIL single_epc: got %h want %h", epc_out, pc); end
      rd(13, v);
      checks++; if (v[9:8] !== 2'b10) begin fails++; $display("FAIL single_lvl: got %b want 10", v[9:8]); end
      rd(12, v);
      checks++; if (v[0] !== 1'b0) begin fails++; $display("FAIL single_ie: got %b want 0", v[0]); end
      eret_op();
      checks++; if (nest_depth !== 4'd0) begin fails++; $display("FAIL single_ret_sp: got %0d want 0", nest_depth); end
      rd(12, v);
      checks++; if (v !== 32'h0000_0701) begin fails++; $display("FAIL single_ret_r12: got %h want 00000701", v); end
      rd(13, v);
      checks++; if (v !== 32'd0) begin fails++; $display("FAIL single_ret_r13: got %h want 0", v); end
   endtask

   task automatic test_nested();
      int lat; logic [31:0] pc1, pc2, v;
      pulse(0); wait_int(8, lat);
      checks++; if (lat != 3) begin fails++; $display("FAIL nest_lat0: got %0d want 3", lat); end
      pc1 = ex_pc; cyc();
      mtc0(12, 32'h0000_0701);
      pulse(2); wait_int(8, lat);
      checks++; if (lat != 3) begin fails++; $display("FAIL nest_lat2: got %0d want 3", lat); end
      pc2 = ex_pc; cyc();
      checks++; if (nest_depth !== 4'd2) begin fails++; $display("FAIL nest_sp2: got %0d want 2", nest_depth); end
      checks++; if (epc_out !== pc2) begin fails++; $display("FAIL nest_epc2: got %h want %h", epc_out, pc2); end
      rd(13, v);
      checks++; if (v[15:8] !== 8'h04) begin fails++; $display("FAIL nest_lvl3: got %h want 04", v[15:8]); end
      eret_op();
      checks++; if (nest_depth !== 4'd1) begin fails++; $display("FAIL nest_ret_sp: got %0d want 1", nest_depth); end
      checks++; if (epc_out !== pc1) begin fails++; $display("FAIL nest_ret_epc: got %h want %h", epc_out, pc1); end
      rd(13, v);
      checks++; if (v[15:8] !== 8'h01) begin fails++; $display("FAIL nest_ret_lvl: got %h want 01", v[15:8]); end
      eret_op();
      checks++; if (nest_depth !== 4'd0) begin fails++; $display("FAIL nest_ret2_sp: got %0d want 0", nest_depth); end
   endtask

   task automatic test_lower();
      int lat;
      pulse(2); wait_int(8, lat); cyc();
      mtc0(12, 32'h0000_0701);
      pulse(1);
      for (int k = 0; k < 6; k++) begin
         cyc();
         checks++; if (INT !== 1'b0) begin fails++; $display("FAIL lower_noint: got %b want 0", INT); end
      end
      eret_op();
      checks++; if (nest_depth !== 4'd0) begin fails++; $display("FAIL lower_sp: got %0d want 0", nest_depth); end
      wait_int(2, lat);
      checks++; if (lat < 1 || lat > 2) begin fails++; $display("FAIL lower_late: got %0d want 1..2", lat); end
      cyc();
      checks++; if (nest_depth !== 4'd1) begin fails++; $display("FAIL lower_take: got %0d want 1", nest_depth); end
      eret_op();
   endtask

   task automatic test_full();
      int lat; logic [31:0] v;
      pulse(0); wait_int(8, lat); cyc();
      mtc0(12, 32'h0000_0701);
      pulse(1); wait_int(8, lat); cyc();
      mtc0(12, 32'h0000_0701);
      pulse(2);
      for (int k = 0; k < 8; k++) begin
         cyc();
         checks++; if (INT !== 1'b0 || nest_depth !== 4'd2) begin fails++; $display("FAIL full_block: got INT=%b sp=%0d want 0 2", INT, nest_depth); end
      end
      rd(13, v);
      checks++; if (v[23:16] !== 8'h07) begin fails++; $display("FAIL full_pend: got %h want 07", v[23:16]); end
      eret_op();
      checks++; if (nest_depth !== 4'd1) begin fails++; $display("FAIL full_pop: got %0d want 1", nest_depth); end
      wait_int(3, lat);
      checks++; if (lat != 1) begin fails++; $display("FAIL full_resume: got %0d want 1", lat); end
      cyc();
      rd(13, v);
      checks++; if (v[15:8] !== 8'h04) begin fails++; $display("FAIL full_lvl: got %h want 04", v[15:8]); end
      eret_op(); eret_op();
      rd(13, v);
      checks++; if (v !== 32'd0 || nest_depth !== 4'd0) begin fails++; $display("FAIL full_clean: got %h sp=%0d want 0 0", v, nest_depth); end
   endtask

   task automatic test_mask();
      int lat; logic [31:0] v;
      mtc0(12, 32'h0000_0601);
      pulse(0);
      for (int k = 0; k < 8; k++) begin
         cyc();
         checks++; if (INT !== 1'b0) begin fails++; $display("FAIL mask_noint: got %b want 0", INT); end
      end
      mtc0(12, 32'h0000_0701);
      wait_int(3, lat);
      checks++; if (lat != 1) begin fails++; $display("FAIL mask_unmask: got %0d want 1", lat); end
      cyc(); eret_op();
      rd(13, v);
      checks++; if (v !== 32'd0) begin fails++; $display("FAIL mask_clean: got %h want 0", v); end
   endtask

   task automatic test_epc_rw();
      int lat; logic [31:0] v, w, pc;
      mtc0(14, $urandom);
      checks++; if (epc_out !== 32'd0) begin fails++; $display("FAIL epc_empty: got %h want 0", epc_out); end
      rd(5, v);
      checks++; if (v !== 32'd0) begin fails++; $display("FAIL rd_other: got %h want 0", v); end
      mtc0(12, 32'h0000_0700);
      eret_op();
      rd(12, v);
      checks++; if (v[0] !== 1'b1) begin fails++; $display("FAIL eret_empty_ie: got %b want 1", v[0]); end
      pulse(0); wait_int(8, lat);
      wb_instr = mtc0_w(12); wb_din = 32'h0000_0701; pc = ex_pc; cyc(); wb_instr = '0;
      rd(12, v);
      checks++; if (v !== 32'h0100_0701) begin fails++; $display("FAIL take_mtc0_ie: got %h want 01000701", v); end
      checks++; if (epc_out !== pc) begin fails++; $display("FAIL take_epc: got %h want %h", epc_out, pc); end
      w = $urandom; mtc0(14, w);
      rd(14, v);
      checks++; if (v !== w || epc_out !== w) begin fails++; $display("FAIL epc_write: got %h/%h want %h", v, epc_out, w); end
      eret_op();
   endtask

   task automatic test_async_reset();
      int lat; logic [31:0] v;
      pulse(0); wait_int(8, lat); cyc();
      mtc0(12, 32'h0000_0701);
      pulse(1); wait_int(8, lat);
      checks++; if (INT !== 1'b1 || nest_depth !== 4'd1) begin fails++; $display("FAIL arst_pre: got INT=%b sp=%0d want 1 1", INT, nest_depth); end
      #1 rst_n = 1'b0; #1;
      checks++; if (INT !== 1'b0 || nest_depth !== 4'd0) begin fails++; $display("FAIL arst_now: got INT=%b sp=%0d want 0 0", INT, nest_depth); end
      rd(12, v);
      checks++; if (v !== 32'h0000_0700) begin fails++; $display("FAIL arst_r12: got %h want 00000700", v); end
      rd(13, v);
      checks++; if (v !== 32'd0) begin fails++; $display("FAIL arst_r13: got %h want 0", v); end
      m_reset();
      @(posedge clk); #1; rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [31:0] d; logic [4:0] a;
      for (int n = 0; n < 600; n++) begin
         intsrc = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b0;
         wb_instr = '0; wb_din = '0;
         case ($urandom_range(0, 9))
            0: begin
               d = $urandom; d[0] = ($urandom_range(0, 3) != 0);
               d[10:8] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
               wb_instr = mtc0_w(12); wb_din = d;
            end
            1: begin wb_instr = mtc0_w(14); wb_din = $urandom; end
            2: begin wb_instr = mtc0_w(13); wb_din = $urandom; end
            default: ;
         endcase
         case ($urandom_range(0, 3))
            0: a = 5'd12;
            1: a = 5'd13;
            2: a = 5'd14;
            default: a = 5'($urandom_range(0, 31));
         endcase
         id_instr = ($urandom_range(0, 5) == 0) ? ERET_W : mfc0_w(a);
         cyc();
         checks++; if (INT !== m_int) begin fails++; $display("FAIL rnd_int@%0d: got %b want %b", n, INT, m_int); end
         checks++; if (nest_depth !== 4'(stk.size())) begin fails++; $display("FAIL rnd_sp@%0d: got %0d want %0d", n, nest_depth, stk.size()); end
         checks++; if (epc_out !== m_epc()) begin fails++; $display("FAIL rnd_epc@%0d: got %h want %h", n, epc_out, m_epc()); end
         checks++; if (id_dout !== m_read(id_instr[15:11])) begin fails++; $display("FAIL rnd_rd@%0d: got %h want %h", n, id_dout, m_read(id_instr[15:11])); end
      end
      intsrc = '0; wb_instr = '0; id_instr = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_nested();
      test_lower();
      test_full();
      test_mask();
      test_epc_rw();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
